// File: rtl/mips_rtype_pkg.sv
// Shared definitions for the two-stage MIPS R-type pipeline: funct encodings,
// ALU operation enum, decoded-instruction struct and the decoder itself.
package mips_rtype_pkg;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [4:0] {
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_NONE
    } alu_op_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        alu_op_e    op;
        logic       legal;
    } dec_instr_t;

    // Split an instruction word into fields and map funct to an ALU op.
    // Anything that is not opcode 0 with a supported funct is flagged illegal.
    function automatic dec_instr_t decode(input logic [31:0] w);
        dec_instr_t d;
        logic       funct_ok;
        d.rs     = w[25:21];
        d.rt     = w[20:16];
        d.rd     = w[15:11];
        d.shamt  = w[10:6];
        funct_ok = 1'b1;
        case (w[5:0])
            F_SLL:   d.op = OP_SLL;
            F_SRL:   d.op = OP_SRL;
            F_SRA:   d.op = OP_SRA;
            F_SLLV:  d.op = OP_SLLV;
            F_SRLV:  d.op = OP_SRLV;
            F_SRAV:  d.op = OP_SRAV;
            F_ADD:   d.op = OP_ADD;
            F_ADDU:  d.op = OP_ADDU;
            F_SUB:   d.op = OP_SUB;
            F_SUBU:  d.op = OP_SUBU;
            F_AND:   d.op = OP_AND;
            F_OR:    d.op = OP_OR;
            F_XOR:   d.op = OP_XOR;
            F_NOR:   d.op = OP_NOR;
            F_SLT:   d.op = OP_SLT;
            F_SLTU:  d.op = OP_SLTU;
            default: begin
                d.op     = OP_NONE;
                funct_ok = 1'b0;
            end
        endcase
        d.legal = funct_ok && (w[31:26] == 6'd0);
        return d;
    endfunction

endpackage

// File: rtl/mips_rtype_alu.sv
// Purely combinational R-type ALU: shifts, add/sub, logic and set-less-than.
// Optional macro RTYPE_OVF_TRAP_EN adds a signed-overflow flag for add/sub.
module mips_rtype_alu
    import mips_rtype_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  alu_op_e            op_i,
    input  logic [XLEN-1:0]    rs_i,
    input  logic [XLEN-1:0]    rt_i,
    input  logic [SHAMT_W-1:0] shamt_i,
`ifdef RTYPE_OVF_TRAP_EN
    output logic               ovf_o,
`endif
    output logic [XLEN-1:0]    res_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  sh_fix_s;
    logic [SHW-1:0]  sh_var_s;
    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] diff_s;
    logic            lt_s;
    logic            ltu_s;

    // Shared intermediates: shift amounts, adder/subtractor, comparisons.
    always_comb begin
        // Immediate shifts wrap modulo XLEN; variable shifts take the low rs bits.
        sh_fix_s = SHW'(32'(shamt_i) % 32'(XLEN));
        sh_var_s = rs_i[SHW-1:0];
        sum_s    = rs_i + rt_i;
        diff_s   = rs_i - rt_i;
        lt_s     = $signed(rs_i) < $signed(rt_i);
        ltu_s    = rs_i < rt_i;
    end

    // Result multiplexer; shifts operate on rt, arithmetic is rs op rt.
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_SLL:  res_o = rt_i << sh_fix_s;
            OP_SRL:  res_o = rt_i >> sh_fix_s;
            OP_SRA:  res_o = $signed(rt_i) >>> sh_fix_s;
            OP_SLLV: res_o = rt_i << sh_var_s;
            OP_SRLV: res_o = rt_i >> sh_var_s;
            OP_SRAV: res_o = $signed(rt_i) >>> sh_var_s;
            OP_ADD:  res_o = sum_s;
            OP_ADDU: res_o = sum_s;
            OP_SUB:  res_o = diff_s;
            OP_SUBU: res_o = diff_s;
            OP_AND:  res_o = rs_i & rt_i;
            OP_OR:   res_o = rs_i | rt_i;
            OP_XOR:  res_o = rs_i ^ rt_i;
            OP_NOR:  res_o = ~(rs_i | rt_i);
            OP_SLT:  res_o = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: res_o = {{(XLEN-1){1'b0}}, ltu_s};
            default: res_o = '0;
        endcase
    end

`ifdef RTYPE_OVF_TRAP_EN
    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // result sign differs from rs.
    always_comb begin
        case (op_i)
            OP_ADD:  ovf_o = (rs_i[XLEN-1] == rt_i[XLEN-1]) && (sum_s[XLEN-1] != rs_i[XLEN-1]);
            OP_SUB:  ovf_o = (rs_i[XLEN-1] != rt_i[XLEN-1]) && (diff_s[XLEN-1] != rs_i[XLEN-1]);
            default: ovf_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mips_rtype_pipe.sv
// Two-stage pipelined MIPS R-type datapath with internal register file.
// S1 holds the issued instruction; the retire edge loads the result register
// and writes rd together, so a dependent instruction in S1 always sees it.
// Optional macro RTYPE_OVF_TRAP_EN: add/sub trap on signed overflow.
module mips_rtype_pipe
    import mips_rtype_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_err,
    input  logic            pre_we,
    input  logic [4:0]      pre_addr,
    input  logic [XLEN-1:0] pre_data
);

    localparam int AW = $clog2(NREGS);

    logic            s1_full_q, s1_full_d;
    logic [31:0]     s1_instr_q, s1_instr_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic [4:0]      res_rd_q, res_rd_d;
    logic            res_err_q, res_err_d;
    logic [XLEN-1:0] rf_q [NREGS];

    logic            stall_s;
    logic            advance_s;
    logic            accept_s;
    dec_instr_t      dec_s;
    logic [AW-1:0]   rs_idx_s, rt_idx_s, rd_idx_s, pre_idx_s;
    logic [XLEN-1:0] rs_val_s, rt_val_s, alu_res_s;
    logic            ovf_s;
    logic            err_s;
    logic            ret_wr_s;
    logic            pre_wr_s;

    // Handshake: a held result blocks retire; S1 can refill only if it drains.
    always_comb begin
        stall_s   = res_valid_q && !res_ready;
        advance_s = s1_full_q && !stall_s;
        in_ready  = !s1_full_q || !stall_s;
        accept_s  = in_valid && in_ready;
    end

    // Decode S1 and read operands; r0 always reads as zero.
    always_comb begin
        dec_s    = decode(s1_instr_q);
        rs_idx_s = dec_s.rs[AW-1:0];
        rt_idx_s = dec_s.rt[AW-1:0];
        rd_idx_s = dec_s.rd[AW-1:0];
        rs_val_s = (rs_idx_s == '0) ? '0 : rf_q[rs_idx_s];
        rt_val_s = (rt_idx_s == '0) ? '0 : rf_q[rt_idx_s];
    end

    mips_rtype_alu #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .op_i    (dec_s.op),
        .rs_i    (rs_val_s),
        .rt_i    (rt_val_s),
        .shamt_i (dec_s.shamt[SHAMT_W-1:0]),
`ifdef RTYPE_OVF_TRAP_EN
        .ovf_o   (ovf_s),
`endif
        .res_o   (alu_res_s)
    );

`ifndef RTYPE_OVF_TRAP_EN
    assign ovf_s = 1'b0;
`endif

    // Write qualification for retire and preload ports.
    always_comb begin
        err_s     = !dec_s.legal || ovf_s;
        ret_wr_s  = advance_s && !err_s && (rd_idx_s != '0);
        pre_wr_s  = pre_we && (32'(pre_addr) < 32'(NREGS)) && (pre_addr != 5'd0);
        pre_idx_s = pre_addr[AW-1:0];
    end

    // Next state for S1 and the result register.
    always_comb begin
        s1_full_d   = s1_full_q;
        s1_instr_d  = s1_instr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_err_d   = res_err_q;
        if (accept_s) begin
            s1_full_d  = 1'b1;
            s1_instr_d = instr;
        end else if (advance_s) begin
            s1_full_d  = 1'b0;
        end else begin
            s1_full_d  = s1_full_q;
        end
        if (advance_s) begin
            res_valid_d = 1'b1;
            // Illegal instructions report zero; overflow traps keep the wrapped value.
            res_data_d  = dec_s.legal ? alu_res_s : '0;
            res_rd_d    = dec_s.rd;
            res_err_d   = err_s;
        end else if (!stall_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_q   <= 1'b0;
            s1_instr_q  <= 32'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= 5'd0;
            res_err_q   <= 1'b0;
        end else begin
            s1_full_q   <= s1_full_d;
            s1_instr_q  <= s1_instr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_err_q   <= res_err_d;
        end
    end

    // Register file; the retire write is issued last so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (pre_wr_s) begin
                rf_q[pre_idx_s] <= pre_data;
            end
            if (ret_wr_s) begin
                rf_q[rd_idx_s] <= alu_res_s;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_mips_rtype_pipe.sv
// Self-checking bench for mips_rtype_pipe against an architectural model.
module tb_mips_rtype_pipe;
    import mips_rtype_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_rd;
    logic            res_err;
    logic            pre_we;
    logic [4:0]      pre_addr;
    logic [XLEN-1:0] pre_data;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } res_t;

    res_t        exp_q[$];
    res_t        got_q[$];
    logic [31:0] ref_rf [32];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    localparam logic [5:0] LEGAL_F [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    mips_rtype_pipe #(.XLEN(XLEN), .NREGS(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .res_err(res_err), .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed result transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) got_q.push_back('{res_data, res_rd, res_err, cyc});
    end

    function automatic logic [31:0] mk_r(input logic [5:0] f, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, f};
    endfunction

    // Architectural model: executes one instruction in program order.
    task automatic model_exec(input logic [31:0] w);
        logic [31:0] a, b, r;
        logic        err;
        int unsigned sh, vsh;
`ifdef RTYPE_OVF_TRAP_EN
        longint      s;
`endif
        a   = ref_rf[w[25:21]];
        b   = ref_rf[w[20:16]];
        sh  = w[10:6];
        vsh = a % 32'd32;
        r   = 32'd0;
        err = 1'b0;
        if (w[31:26] != 6'd0) begin
            err = 1'b1;
        end else begin
            case (w[5:0])
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = 32'($signed(b) >>> sh);
                6'h04: r = b << vsh;
                6'h06: r = b >> vsh;
                6'h07: r = 32'($signed(b) >>> vsh);
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                default: err = 1'b1;
            endcase
`ifdef RTYPE_OVF_TRAP_EN
            if (w[5:0] == 6'h20 || w[5:0] == 6'h22) begin
                s = (w[5:0] == 6'h20) ? longint'($signed(a)) + longint'($signed(b))
                                      : longint'($signed(a)) - longint'($signed(b));
                if (s > 64'sd2147483647 || s < -64'sd2147483648) err = 1'b1;
            end
`endif
        end
        if (!err && w[15:11] != 5'd0) ref_rf[w[15:11]] = r;
        exp_q.push_back('{r, w[15:11], err, 0});
    endtask

    // Offer one instruction and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] w);
        int t = 0;
        model_exec(w);
        in_valid = 1'b1;
        instr    = w;
        @(negedge clk);
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        instr    = 32'd0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
        if (a != 5'd0) ref_rf[a] = v;
    endtask

    task automatic drain;
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        int unsigned k = $urandom_range(0, 19);
        logic [5:0]  op = 6'd0;
        logic [5:0]  f  = LEGAL_F[$urandom_range(0, 15)];
        if (k == 16) f = 6'h3F;
        else if (k == 17) f = 6'h01;
        else if (k == 18) op = 6'($urandom_range(1, 63));
        else f = f;
        return {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), f};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0 || res_err !== 1'b0 || res_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b err=%b data=%h, want 0 0 0", res_valid, res_err, res_data);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [31:0] want_d [2] = '{32'd12, 32'd12};
        logic [4:0]  want_r [2] = '{5'd3, 5'd4};
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        model_exec(mk_r(F_ADD, 5'd1, 5'd2, 5'd3, 5'd0));
        in_valid = 1'b1; instr = mk_r(F_ADD, 5'd1, 5'd2, 5'd3, 5'd0);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_accept: in_ready=%b want 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        // First edge (accept) leaves the result register empty; second edge fills it.
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early: res_valid=%b want 0", res_valid); end
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 32'd12 || res_rd !== 5'd3) begin
            n_bad++;
            $display("FAIL basic_latency: valid=%b data=%h rd=%0d, want 1 0000000c 3", res_valid, res_data, res_rd);
        end
        @(posedge clk); #1;
        send(mk_r(F_OR, 5'd3, 5'd0, 5'd4, 5'd0));
        drain;
        n_vec++;
        if (got_q.size() != 2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== want_d[i] || got_q[i].rd !== want_r[i] || got_q[i].err !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_res[%0d]: got %h rd=%0d err=%b, want %h rd=%0d err=0",
                         i, got_q[i].data, got_q[i].rd, got_q[i].err, want_d[i], want_r[i]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [31:0] want_d [3] = '{32'd12, 32'd24, 32'd19};
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        res_ready = 1'b1;
        send(mk_r(F_ADDU, 5'd1, 5'd2, 5'd3, 5'd0));
        send(mk_r(F_ADDU, 5'd3, 5'd3, 5'd4, 5'd0));
        send(mk_r(F_SUBU, 5'd4, 5'd1, 5'd5, 5'd0));
        drain;
        n_vec++;
        if (got_q.size() != 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== want_d[i] || got_q[i].err !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_res[%0d]: got %h err=%b, want %h err=0", i, got_q[i].data, got_q[i].err, want_d[i]);
            end
            if (i > 0) begin
                n_vec++;
                if (got_q[i].cyc !== got_q[i-1].cyc + 1) begin
                    n_bad++;
                    $display("FAIL b2b_bubble[%0d]: got cycle %0d, want %0d", i, got_q[i].cyc, got_q[i-1].cyc + 1);
                end
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_xlen;
        logic [31:0] want_d [5] = '{32'hF8000000, 32'h0000000F, 32'd1, 32'd0, 32'h80000000};
        preload(5'd7, 32'h80000000);
        preload(5'd25, 32'd36);
        preload(5'd26, 32'h000000F0);
        preload(5'd28, 32'hFFFFFFFF);
        preload(5'd29, 32'd1);
        send(mk_r(F_SRA,  5'd0,  5'd7,  5'd6,  5'd4));
        send(mk_r(F_SRLV, 5'd25, 5'd26, 5'd27, 5'd0));
        send(mk_r(F_SLT,  5'd28, 5'd29, 5'd30, 5'd0));
        send(mk_r(F_SLTU, 5'd28, 5'd29, 5'd31, 5'd0));
        send(mk_r(F_SLL,  5'd0,  5'd29, 5'd8,  5'd31));
        drain;
        n_vec++;
        if (got_q.size() != 5) begin n_bad++; $display("FAIL xlen_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== want_d[i] || got_q[i].err !== 1'b0) begin
                n_bad++;
                $display("FAIL xlen_res[%0d]: got %h err=%b, want %h err=0", i, got_q[i].data, got_q[i].err, want_d[i]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_stall;
        res_ready = 1'b0;
        fork
            begin
                send(mk_r(F_ADDU, 5'd1, 5'd2, 5'd12, 5'd0));
                send(mk_r(F_SUBU, 5'd2, 5'd1, 5'd13, 5'd0));
                send(mk_r(F_XOR,  5'd1, 5'd2, 5'd14, 5'd0));
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                n_vec++;
                if (in_ready !== 1'b0 || res_valid !== 1'b1 || got_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL stall_hold: in_ready=%b valid=%b transfers=%0d, want 0 1 0",
                             in_ready, res_valid, got_q.size());
                end
                n_vec++;
                if (res_data !== exp_q[0].data || res_rd !== exp_q[0].rd) begin
                    n_bad++;
                    $display("FAIL stall_front: got %h rd=%0d, want %h rd=%0d", res_data, res_rd, exp_q[0].data, exp_q[0].rd);
                end
                @(posedge clk); #1 res_ready = 1'b1;
            end
        join
        drain;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rd !== exp_q[i].rd || got_q[i].err !== exp_q[i].err) begin
                n_bad++;
                $display("FAIL stall_res[%0d]: got %h rd=%0d err=%b, want %h rd=%0d err=%b", i,
                         got_q[i].data, got_q[i].rd, got_q[i].err, exp_q[i].data, exp_q[i].rd, exp_q[i].err);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_illegal;
        preload(5'd15, 32'h00001234);
        send({6'h08, 5'd1, 5'd2, 5'd15, 5'd0, 6'h20});
        send(mk_r(6'h3F, 5'd1, 5'd2, 5'd15, 5'd0));
        send(mk_r(F_OR,   5'd15, 5'd0, 5'd16, 5'd0));
        send(mk_r(F_ADDU, 5'd1,  5'd2, 5'd0,  5'd0));
        send(mk_r(F_OR,   5'd0,  5'd0, 5'd17, 5'd0));
        // Preload to r0 is discarded as well; the read must stay zero.
        preload(5'd0, 32'h55555555);
        send(mk_r(F_OR,   5'd0,  5'd0, 5'd18, 5'd0));
        drain;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL illegal_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rd !== exp_q[i].rd || got_q[i].err !== exp_q[i].err) begin
                n_bad++;
                $display("FAIL illegal_res[%0d]: got %h rd=%0d err=%b, want %h rd=%0d err=%b", i,
                         got_q[i].data, got_q[i].rd, got_q[i].err, exp_q[i].data, exp_q[i].rd, exp_q[i].err);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_preload_collision;
        send(mk_r(F_ADDU, 5'd1, 5'd2, 5'd9, 5'd0));
        // This edge retires the addu into r9 while a preload targets r9.
        pre_we = 1'b1; pre_addr = 5'd9; pre_data = 32'hDEADBEEF;
        @(posedge clk); #1 pre_we = 1'b0;
        send(mk_r(F_OR, 5'd9, 5'd0, 5'd10, 5'd0));
        drain;
        n_vec++;
        if (got_q.size() != 2) begin n_bad++; $display("FAIL collide_count: got %0d want 2", got_q.size()); end
        n_vec++;
        if (got_q.size() == 2 && got_q[1].data !== exp_q[1].data) begin
            n_bad++; $display("FAIL collide_res: r9 reads %h, want %h", got_q[1].data, exp_q[1].data);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow;
        preload(5'd20, 32'h7FFFFFFF);
        preload(5'd21, 32'd1);
        preload(5'd22, 32'hAAAA0001);
        preload(5'd24, 32'h80000000);
        preload(5'd23, 32'hAAAA0002);
        send(mk_r(F_ADD,  5'd20, 5'd21, 5'd22, 5'd0));
        send(mk_r(F_SUB,  5'd24, 5'd21, 5'd23, 5'd0));
        send(mk_r(F_ADDU, 5'd20, 5'd21, 5'd11, 5'd0));
        send(mk_r(F_OR,   5'd22, 5'd0,  5'd19, 5'd0));
        send(mk_r(F_OR,   5'd23, 5'd0,  5'd19, 5'd0));
        drain;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rd !== exp_q[i].rd || got_q[i].err !== exp_q[i].err) begin
                n_bad++;
                $display("FAIL ovf_res[%0d]: got %h rd=%0d err=%b, want %h rd=%0d err=%b", i,
                         got_q[i].data, got_q[i].rd, got_q[i].err, exp_q[i].data, exp_q[i].rd, exp_q[i].err);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random;
        bit done = 1'b0;
        for (int r = 1; r < 32; r++) begin
            case (r % 5)
                0:       preload(5'(r), 32'h80000000);
                1:       preload(5'(r), 32'hFFFFFFFF);
                2:       preload(5'(r), 32'h7FFFFFFF);
                default: preload(5'(r), $urandom);
            endcase
        end
        fork
            begin
                for (int k = 0; k < 250; k++) send(gen_instr());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
        join
        drain;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rd !== exp_q[i].rd || got_q[i].err !== exp_q[i].err) begin
                n_bad++;
                $display("FAIL random_res[%0d]: got %h rd=%0d err=%b, want %h rd=%0d err=%b", i,
                         got_q[i].data, got_q[i].rd, got_q[i].err, exp_q[i].data, exp_q[i].rd, exp_q[i].err);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midstream;
        res_ready = 1'b0;
        send(mk_r(F_ADDU, 5'd1, 5'd2, 5'd3, 5'd0));
        send(mk_r(F_XOR,  5'd3, 5'd1, 5'd4, 5'd0));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0 || res_data !== 32'd0 || res_err !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_state: valid=%b data=%h err=%b in_ready=%b, want 0 0 0 1",
                     res_valid, res_data, res_err, in_ready);
        end
        n_vec++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL midreset_leak: got %0d transfers want 0", got_q.size()); end
        exp_q.delete(); got_q.delete();
        foreach (ref_rf[i]) ref_rf[i] = 32'd0;
        @(posedge clk); #1 res_ready = 1'b1;
        for (int r = 1; r < 32; r++) send(mk_r(F_OR, 5'(r), 5'd0, 5'(r), 5'd0));
        drain;
        n_vec++;
        if (got_q.size() != 31) begin n_bad++; $display("FAIL midreset_count: got %0d want 31", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i].data !== 32'd0 || got_q[i].err !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_reg[%0d]: got %h err=%b, want 00000000 err=0", i + 1, got_q[i].data, got_q[i].err);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = 32'd0; res_ready = 1'b1;
        pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;
        foreach (ref_rf[i]) ref_rf[i] = 32'd0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_xlen;
        test_stall;
        test_illegal;
        test_preload_collision;
        test_overflow;
        test_random;
        test_reset_midstream;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
